sonic_sensor_arbiter: RTL and testbench
=======================================

// Module: sonic_sensor_arbiter
// PURPOSE
//  Shares one sonic_sensor instance (req/busy/finish/out_data) between NUM_REQ requesters.
//  Round-robin grant; sequences trigger -> busy -> finish; returns the tagged result to the winner.
//  Enforces a minimum echo-decay gap between measurements. Sits between the per-channel FIFO
//  controllers and the single sensor.
// PARAMETERS
//  NUM_REQ      4        number of requesters (2..16)
//  DATA_W       32       sensor result width
//  GAP_CYC      16       idle guard cycles after each measurement (0 = no guard)
//  TIMEOUT_CYC  1000000  watchdog limit in cycles (used only with SONIC_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous, active-high reset
//  req_in       in   NUM_REQ      level request per requester; hold until ack_out
//  ack_out      out  NUM_REQ      one-cycle pulse to the served requester; rsp_* valid that cycle
//  rsp_data     out  DATA_W       measurement result, registered
//  rsp_id       out  ID_W         index of the served requester, ID_W = clog2(NUM_REQ)
//  rsp_err      out  1            timeout flag, qualified by ack_out
//  sens_req     out  1            to sonic_sensor.req; one-cycle trigger pulse
//  sens_busy    in   1            from sonic_sensor.busy
//  sens_finish  in   1            from sonic_sensor.finish
//  sens_data    in   DATA_W       from sonic_sensor.out_data
//  active       out  1            high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, RR pointer=0, ack_out=0, rsp_data=0, rsp_id=0, rsp_err=0, sens_req=0, gap/wdog counters=0.
//  Reset mid-measurement: same values next cycle. The in-flight result is dropped and no ack is issued.
//  FSM states:
//   IDLE      -> ISSUE     when |req_in. Winner = first set bit at or after pointer (wrapping); grant id latched.
//   ISSUE     -> WAIT_BUSY unconditionally. sens_req=1 only in this state (exactly 1 cycle).
//   WAIT_BUSY -> WAIT_DONE on sens_busy.
//                -> RESP on sens_finish && !sens_busy (sensor done without a visible busy phase).
//   WAIT_DONE -> RESP      on sens_finish && !sens_busy. sens_data is captured into rsp_data on that edge.
//   RESP      -> GUARD (GAP_CYC>0, counter loads GAP_CYC-1) or -> IDLE (GAP_CYC=0).
//                ack_out[id]=1 for this cycle only; pointer <= (id+1) mod NUM_REQ.
//   GUARD     -> IDLE      when counter==0, otherwise decrement. Requests are not sampled here.
//  Latency: req seen in IDLE at cycle t -> sens_req at t+1; finish sampled at t_f -> ack_out at t_f+1.
//  Handshake: the requester must drop req_in no later than the cycle after ack_out.
//   A req_in still high in IDLE is a new request and is arbitrated normally.
//   A req_in dropped after grant does not abort: the measurement completes and ack_out still pulses.
//  Fairness: with all req_in high, grants go 0,1,2,..,NUM_REQ-1,0...
//   No requester waits more than NUM_REQ-1 measurements.
//  Wraparound: pointer NUM_REQ-1 -> 0. The search wraps, e.g. ptr=3 with req=0001 grants 0.
//  sens_finish/sens_busy outside WAIT_* are ignored.
// CONFIGURATION
//  SONIC_ARB_TIMEOUT_EN defined:
//   - Watchdog counts cycles in WAIT_BUSY+WAIT_DONE; it is cleared on entry to ISSUE.
//   - On reaching TIMEOUT_CYC-1 the FSM goes to RESP with rsp_err=1 and rsp_data=0.
//   - If finish and timeout occur in the same cycle, finish wins and rsp_err=0.
//  SONIC_ARB_TIMEOUT_EN undefined: no watchdog logic; the FSM waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  Package sonic_arb_pkg: state encoding localparams (IDLE..GUARD, 3 bits), clog2 function, ID_W derivation.
//  Sub-module sonic_rr_pick: combinational round-robin picker (req vector, pointer -> valid, winner index).
//  Everything else (FSM, counters, result registers) lives in this module.
// TESTING
//  1. Single requester: req_in=0001, sensor busy 5 cycles, data 0x1234
//     -> sens_req one pulse at t+1, ack_out=0001, rsp_data=0x1234, rsp_id=0, rsp_err=0.
//  2. All four requesting continuously, GAP_CYC=16
//     -> ack order 0,1,2,3,0; exactly 16 idle cycles between ack and the next sens_req+1.
//  3. Pointer wrap: last grant was id 3, req_in=0101 -> next grant id 0, then id 2.
//  4. No-busy sensor: finish=1 and busy=0 on the cycle after ISSUE -> ack 2 cycles after sens_req.
//  5. rst asserted during WAIT_DONE, finish arrives after rst drops
//     -> no ack, all outputs 0, next request served from pointer 0.
//  6. TIMEOUT_EN, TIMEOUT_CYC=100, sensor never finishes
//     -> ack with rsp_err=1, rsp_data=0 100 cycles after ISSUE.
//     Without the macro -> no ack, active stays 1.

Source files
------------

// File: rtl/sonic_arb_pkg.sv
// Shared types and helpers for the sonic sensor arbiter: state encoding and width derivation.
package sonic_arb_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;
    localparam logic [2:0] ST_GUARD     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_BUSY = ST_WAIT_BUSY,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_RESP      = ST_RESP,
        S_GUARD     = ST_GUARD
    } arb_state_t;

    function automatic int arb_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Minimum of one bit so degenerate counts still give a legal vector.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : arb_clog2(n);
    endfunction

endpackage

// File: rtl/sonic_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping past NUM_REQ-1.
module sonic_rr_pick
    import sonic_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;

    always_comb begin
        rot   = NUM_REQ'({req, req} >> ptr);
        valid = |req;
        sum   = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) sum = (ID_W + 1)'(i);
        end
        sum = sum + {1'b0, ptr};
        if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
        winner = sum[ID_W-1:0];
    end

endmodule

// File: rtl/sonic_sensor_arbiter.sv
// Round-robin arbiter sharing one sonic sensor among NUM_REQ requesters, with echo-decay guard.
// Optional watchdog on the sensor wait phase: define SONIC_ARB_TIMEOUT_EN.
//
//  state     | meaning
//  IDLE      | no measurement; arbitrate req_in
//  ISSUE     | one-cycle sens_req pulse to the sensor
//  WAIT_BUSY | waiting for the sensor to raise busy (or finish directly)
//  WAIT_DONE | sensor busy; waiting for finish
//  RESP      | ack_out pulse with rsp_* valid; advance RR pointer
//  GUARD     | echo-decay gap; requests ignored
module sonic_sensor_arbiter
    import sonic_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] ack_out,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_err,
    output logic               sens_req,
    input  logic               sens_busy,
    input  logic               sens_finish,
    input  logic [DATA_W-1:0]  sens_data,
    output logic               active
);

    localparam int                 GAP_W    = id_width(GAP_CYC);
    localparam logic [GAP_W-1:0]   GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
    localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  grant_id;
    logic [GAP_W-1:0] gap_cnt;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_id;

`ifdef SONIC_ARB_TIMEOUT_EN
    localparam int                WD_W    = id_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]   WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0]              wdog;
`else
    assign rsp_err = 1'b0;
`endif

    sonic_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_in),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            grant_id <= '0;
            gap_cnt  <= '0;
            ack_out  <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            sens_req <= 1'b0;
            active   <= 1'b0;
`ifdef SONIC_ARB_TIMEOUT_EN
            rsp_err  <= 1'b0;
            wdog     <= '0;
`endif
        end else begin
            ack_out  <= '0;
            sens_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_id;
                        sens_req <= 1'b1;
                        active   <= 1'b1;
                        state    <= S_ISSUE;
`ifdef SONIC_ARB_TIMEOUT_EN
                        // Down-counter runs from ISSUE so terminal count lands TIMEOUT_CYC after the trigger.
                        wdog     <= WD_LOAD;
`endif
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_BUSY;
`ifdef SONIC_ARB_TIMEOUT_EN
                    if (wdog != '0) wdog <= wdog - 1'b1;
`endif
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (sens_finish && !sens_busy) begin
                        state    <= S_RESP;
                        ack_out  <= ACK_ONE << grant_id;
                        rsp_id   <= grant_id;
                        rsp_data <= sens_data;
`ifdef SONIC_ARB_TIMEOUT_EN
                        rsp_err  <= 1'b0;
`endif
                    end
`ifdef SONIC_ARB_TIMEOUT_EN
                    else if (wdog == '0) begin
                        state    <= S_RESP;
                        ack_out  <= ACK_ONE << grant_id;
                        rsp_id   <= grant_id;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
`endif
                    else if (state == S_WAIT_BUSY && sens_busy) begin
                        state <= S_WAIT_DONE;
                    end
`ifdef SONIC_ARB_TIMEOUT_EN
                    if (wdog != '0) wdog <= wdog - 1'b1;
`endif
                end
                S_RESP: begin
                    ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    if (GAP_CYC > 0) begin
                        state   <= S_GUARD;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                    end
                end
                S_GUARD: begin
                    if (gap_cnt == '0) begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_sensor_arbiter.sv
// Directed bench for sonic_sensor_arbiter with a simple behavioural sensor model.
module tb_sonic_sensor_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 32;
    localparam int GAP_CYC     = 16;
    localparam int TIMEOUT_CYC = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_in;
    logic [3:0]        ack_out;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_err;
    logic              sens_req;
    logic              sens_busy;
    logic              sens_finish;
    logic [31:0]       sens_data;
    logic              active;

    sonic_sensor_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_in      (req_in),
        .ack_out     (ack_out),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err),
        .sens_req    (sens_req),
        .sens_busy   (sens_busy),
        .sens_finish (sens_finish),
        .sens_data   (sens_data),
        .active      (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int req_cyc_q[$];
    always @(negedge clk) if (sens_req === 1'b1) req_cyc_q.push_back(cyc);

    // Sensor model: 0 = busy for busy_len cycles then finish, 1 = finish without busy, 2 = stuck busy
    int          sens_mode = 0;
    int          busy_len  = 1;
    logic [31:0] data_base = '0;
    int          meas_n    = 0;

    initial begin
        sens_busy   = 1'b0;
        sens_finish = 1'b0;
        sens_data   = '0;
        forever begin
            @(negedge clk);
            if (sens_req === 1'b1) begin
                case (sens_mode)
                    0: begin
                        @(posedge clk); #1 sens_busy = 1'b1;
                        repeat (busy_len) @(posedge clk);
                        #1 sens_busy = 1'b0;
                        sens_finish = 1'b1;
                        sens_data   = data_base + 32'(meas_n);
                        meas_n++;
                        @(posedge clk); #1 sens_finish = 1'b0;
                    end
                    1: begin
                        @(posedge clk); #1 sens_finish = 1'b1;
                        sens_data = data_base + 32'(meas_n);
                        meas_n++;
                        @(posedge clk); #1 sens_finish = 1'b0;
                    end
                    default: begin
                        @(posedge clk); #1 sens_busy = 1'b1;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ack_out", 64'(ack_out), 64'h0);
        chk("rst rsp_data", 64'(rsp_data), 64'h0);
        chk("rst rsp_id", 64'(rsp_id), 64'h0);
        chk("rst rsp_err", 64'(rsp_err), 64'h0);
        chk("rst sens_req", 64'(sens_req), 64'h0);
        chk("rst active", 64'(active), 64'h0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int max, output int at, output logic [3:0] av);
        at = -1;
        av = '0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (|ack_out) begin
                at = cyc;
                av = ack_out;
                break;
            end
        end
        if (at < 0) chk({tag, " ack wait"}, 64'h0, 64'h1);
    endtask

    task automatic release_req(input logic [3:0] av);
        tick();
        req_in = req_in & ~av;
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (active === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({tag, " idle wait"}, 64'h0, 64'h1);
    endtask

    task automatic serve(input string tag, input logic [3:0] mask, input int exp_id);
        int         at;
        logic [3:0] av;
        tick();
        req_in = req_in | mask;
        wait_ack(tag, 100, at, av);
        chk({tag, " id"}, 64'(rsp_id), 64'(exp_id));
        chk({tag, " ack"}, 64'(av), 64'(4'b0001 << exp_id));
        release_req(av);
        wait_idle(tag);
    endtask

    int         t;
    int         at;
    int         ack_at[5];
    int         n_ack;
    logic [3:0] av;

    initial begin
        rst    = 1'b1;
        req_in = '0;

        // 1: single requester, 5 busy cycles
        do_reset();
        tick();
        sens_mode = 0; busy_len = 5; data_base = 32'h1234; meas_n = 0;
        req_cyc_q.delete();
        t = cyc;
        req_in = 4'b0001;
        wait_ack("t1", 60, at, av);
        chk("t1 trigger count", 64'(req_cyc_q.size()), 64'd1);
        chk("t1 trigger cycle", 64'((req_cyc_q.size() > 0) ? req_cyc_q[0] : -1), 64'(t + 1));
        chk("t1 ack cycle", 64'(at), 64'(t + 8));
        chk("t1 ack", 64'(av), 64'h1);
        chk("t1 data", 64'(rsp_data), 64'h1234);
        chk("t1 id", 64'(rsp_id), 64'h0);
        chk("t1 err", 64'(rsp_err), 64'h0);
        release_req(av);
        wait_idle("t1");

        // 2: all requesting continuously, guard spacing
        do_reset();
        tick();
        sens_mode = 0; busy_len = 3; data_base = 32'h100; meas_n = 0;
        req_cyc_q.delete();
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack("t2", 100, ack_at[k], av);
            chk($sformatf("t2 id[%0d]", k), 64'(rsp_id), 64'(k % 4));
            chk($sformatf("t2 ack[%0d]", k), 64'(av), 64'(4'b0001 << (k % 4)));
            chk($sformatf("t2 data[%0d]", k), 64'(rsp_data), 64'(32'h100 + k));
        end
        tick();
        req_in = '0;
        wait_idle("t2");
        chk("t2 trigger count", 64'(req_cyc_q.size()), 64'd5);
        // GUARD holds GAP_CYC cycles, then one IDLE cycle, then ISSUE.
        for (int k = 0; k < 4; k++) begin
            if (req_cyc_q.size() > k + 1)
                chk($sformatf("t2 gap[%0d]", k), 64'(req_cyc_q[k+1] - ack_at[k]), 64'(GAP_CYC + 2));
        end

        // 3: pointer wrap (pointer is 1 here)
        sens_mode = 0; busy_len = 2; data_base = 32'h200; meas_n = 0;
        serve("t3a", 4'b0100, 2);
        serve("t3b", 4'b0001, 0);
        serve("t3c", 4'b1000, 3);
        tick();
        req_in = 4'b0101;
        wait_ack("t3d", 100, at, av);
        chk("t3d id", 64'(rsp_id), 64'h0);
        release_req(av);
        wait_ack("t3e", 100, at, av);
        chk("t3e id", 64'(rsp_id), 64'h2);
        release_req(av);
        wait_idle("t3e");

        // 4: sensor finishes without a busy phase (pointer is 3)
        sens_mode = 1; data_base = 32'hBEEF; meas_n = 0;
        req_cyc_q.delete();
        tick();
        req_in = 4'b0010;
        wait_ack("t4", 60, at, av);
        chk("t4 latency", 64'((req_cyc_q.size() > 0) ? at - req_cyc_q[$] : -1), 64'd2);
        chk("t4 id", 64'(rsp_id), 64'h1);
        chk("t4 data", 64'(rsp_data), 64'hBEEF);
        release_req(av);
        wait_idle("t4");

        // 5: reset during WAIT_DONE, late finish ignored (pointer is 2)
        sens_mode = 2;
        tick();
        req_in = 4'b0100;
        repeat (6) tick();
        rst    = 1'b1;
        req_in = '0;
        tick();
        rst         = 1'b0;
        sens_busy   = 1'b0;
        sens_finish = 1'b1;
        sens_data   = 32'hDEAD;
        @(negedge clk);
        chk("t5 ack_out", 64'(ack_out), 64'h0);
        chk("t5 rsp_data", 64'(rsp_data), 64'h0);
        chk("t5 rsp_id", 64'(rsp_id), 64'h0);
        chk("t5 rsp_err", 64'(rsp_err), 64'h0);
        chk("t5 sens_req", 64'(sens_req), 64'h0);
        chk("t5 active", 64'(active), 64'h0);
        tick();
        sens_finish = 1'b0;
        n_ack = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (|ack_out) n_ack++;
        end
        chk("t5 stray ack", 64'(n_ack), 64'h0);
        sens_mode = 0; busy_len = 2; data_base = 32'h55; meas_n = 0;
        serve("t5 post", 4'b1010, 1);

        // 6: sensor never finishes (pointer is 2)
        sens_mode = 2;
        req_cyc_q.delete();
        tick();
        req_in = 4'b0001;
`ifdef SONIC_ARB_TIMEOUT_EN
        wait_ack("t6", 300, at, av);
        chk("t6 timeout cycle", 64'((req_cyc_q.size() > 0) ? at - req_cyc_q[0] : -1), 64'(TIMEOUT_CYC));
        chk("t6 err", 64'(rsp_err), 64'h1);
        chk("t6 data", 64'(rsp_data), 64'h0);
        chk("t6 id", 64'(rsp_id), 64'h0);
        release_req(av);
        sens_busy = 1'b0;
        wait_idle("t6");
`else
        n_ack = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (|ack_out) n_ack++;
        end
        chk("t6 no ack", 64'(n_ack), 64'h0);
        chk("t6 active", 64'(active), 64'h1);
        sens_busy = 1'b0;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1);
    end

endmodule
